pipe_datapath_memory: RTL and testbench
=======================================

// Module: pipe_datapath_Memory
// PURPOSE
//  M-stage load/store unit of the 5-stage RV32I pipeline; the producer side of the W-stage read-data path.
//  Converts EX/MEM memory ops into a valid/ready request plus a response handshake on the data memory.
//  Byte-lane steers stores, extracts and extends loads, and stalls the pipeline until the access completes.
//  o_lsu_ReadDataW is a register that drives the W-stage read-data input directly.
// PARAMETERS
//  READDATA_INIT  0   reset value of o_lsu_ReadDataW (`XLEN bits; `XLEN comes from riscv_configs.v)
// PORTS
//  i_clk             in   1       clock, rising edge
//  i_rst             in   1       reset, asynchronous, active-high
//  i_lsu_ReqM        in   1       M-stage instr is a load/store
//  i_lsu_WeM         in   1       1=store, 0=load
//  i_lsu_Funct3M     in   3       width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_lsu_AddrM       in   XLEN    byte address (ALU result)
//  i_lsu_WriteDataM  in   XLEN    store data, rs2
//  o_lsu_StallM      out  1       stall F/D/E/M; bubble into W
//  o_lsu_ReadDataW   out  XLEN    extended load result, registered
//  o_lsu_MisalignW   out  1       misaligned-access pulse (see CONFIGURATION)
//  o_dmem_ReqValid   out  1       request valid
//  i_dmem_ReqReady   in   1       request accepted
//  o_dmem_We         out  1       write enable
//  o_dmem_Be         out  4       byte enables
//  o_dmem_Addr       out  XLEN    word-aligned address {A[31:2],2'b00}
//  o_dmem_WData      out  XLEN    lane-replicated store data
//  i_dmem_RspValid   in   1       load data valid
//  i_dmem_RData      in   XLEN    load data word
// BEHAVIOUR
//  - FSM states IDLE, REQ, RSP, DONE. Reset: IDLE. All o_dmem_* = 0, StallM = 0, MisalignW = 0, ReadDataW = READDATA_INIT.
//  - IDLE: on ReqM, latch We/Funct3/Addr/WData and go to REQ. Otherwise stay in IDLE. RspValid is ignored in IDLE.
//  - REQ: ReqValid=1. Addr, Be, WData and We come from registers and stay stable until ReqReady.
//    On ReqValid&ReqReady: a store goes to DONE (complete on acceptance); a load goes to RSP.
//  - RSP: on RspValid, ReadDataW <= extend(lane(RData)), then go to DONE.
//  - DONE: one cycle with StallM=0 so the instr advances. Then IDLE. ReqM is ignored in DONE (same instr).
//  - StallM = (IDLE & ReqM) | REQ | RSP (combinational).
//  - Minimum latency with ready and response each in 1 cycle: load 4 cycles in M, store 3.
//  - Back-to-back ops: the next op is accepted in the IDLE cycle after DONE.
//  - ReadDataW holds its value until the next load capture. Stores never change it.
//  - Store steering. SB: Be = 4'b0001<<A[1:0], WData = {4{rs2[7:0]}}.
//    SH: Be = 4'b0011<<{A[1],1'b0}, WData = {2{rs2[15:0]}}. SW: Be = 4'hF.
//  - Load extract uses the latched A[1:0]. B and H sign-extend; BU and HU zero-extend.
//  - Funct3 011, 110, 111 are treated as W. Loads drive Be = 4'hF.
//  - Async reset mid-access drops the access. A response arriving later is ignored.
// CONFIGURATION
//  RISCV_LSU_MISALIGN_TRAP_EN defined:
//    H with A[0]=1, or W with A[1:0]!=0, issues no request. FSM goes IDLE->DONE.
//    MisalignW=1 in the DONE cycle only. ReadDataW is unchanged.
//  Undefined: no check. H ignores A[0]; W ignores A[1:0]. MisalignW is tied to 0.
// STRUCTURE
//  riscv_configs.v: add `LSU_F3_LB/LH/LW/LBU/LHU and the FSM state encodings `LSU_S_IDLE..`LSU_S_DONE.
//  Sub-module riscv_lsu_align: combinational store lane steering and load extract/extend.
//  This block holds the FSM, the latches and the ReadDataW register.
// TESTING
//  1 SW A=0x100 D=0xDEADBEEF, ready at once -> Be=F, Addr=0x100, WData=0xDEADBEEF; StallM high 2 cycles.
//  2 Mem[0x100]=0x80F0_7F01; LB A=0x103 -> 0xFFFFFF80; LBU A=0x103 -> 0x00000080; LH A=0x102 -> 0xFFFF80F0.
//  3 SB A=0x102 D=0x000000AB -> Be=0100, WData=0xABABABAB. SH A=0x102 D=0x1234 -> Be=1100, WData=0x12341234.
//  4 ReqReady held 0 for 3 cycles, then RspValid delayed 2 cycles -> ReqValid/Addr stable; StallM high throughout.
//  5 i_rst pulsed while in RSP, late RspValid with 0x55 -> state IDLE, ReadDataW=READDATA_INIT, no stall.
//  6 With RISCV_LSU_MISALIGN_TRAP_EN: LW A=0x101 -> no ReqValid, MisalignW pulses once.
//    Without it: LW A=0x101 -> Addr=0x100, Be=F.

Source files
------------

// File: rtl/pipe_datapath_memory_pkg.sv
// Shared types, widths and helpers for the M-stage load/store unit.
// Optional misalignment trap is selected by RISCV_LSU_MISALIGN_TRAP_EN.
package pipe_datapath_memory_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LSU_F3_LB  = 3'b000;
  localparam logic [2:0] LSU_F3_LH  = 3'b001;
  localparam logic [2:0] LSU_F3_LW  = 3'b010;
  localparam logic [2:0] LSU_F3_LBU = 3'b100;
  localparam logic [2:0] LSU_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_S_IDLE = 2'd0,
    LSU_S_REQ  = 2'd1,
    LSU_S_RSP  = 2'd2,
    LSU_S_DONE = 2'd3
  } lsuState_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsuSize_e;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmemReq_t;

  // Unlisted funct3 encodings fall back to a full word access.
  function automatic lsuSize_e sizeOf(input logic [2:0] funct3);
    case (funct3)
      LSU_F3_LB, LSU_F3_LBU: sizeOf = SZ_B;
      LSU_F3_LH, LSU_F3_LHU: sizeOf = SZ_H;
      default:               sizeOf = SZ_W;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    case (sizeOf(funct3))
      SZ_H:    isMisaligned = addrLo[0];
      SZ_W:    isMisaligned = |addrLo;
      default: isMisaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_datapath_memory_align.sv
// Combinational byte-lane steering for stores and lane extract/extend for loads.
module pipe_datapath_memory_align
  import pipe_datapath_memory_pkg::*;
(
  input  logic [2:0]      stFunct3,
  input  logic [1:0]      stAddrLo,
  input  logic [XLEN-1:0] stData,
  output logic [BE_W-1:0] stBe,
  output logic [XLEN-1:0] stWData,
  input  logic [2:0]      ldFunct3,
  input  logic [1:0]      ldAddrLo,
  input  logic [XLEN-1:0] ldData,
  output logic [XLEN-1:0] ldResult
);

  logic [XLEN-1:0] byteShift;
  logic [XLEN-1:0] halfShift;
  logic            ldUnsigned;

  // Store lanes: narrow data is replicated so memory picks it up via Be.
  always_comb begin
    stBe    = '1;
    stWData = stData;
    case (sizeOf(stFunct3))
      SZ_B: begin
        stBe    = 4'b0001 << stAddrLo;
        stWData = {4{stData[7:0]}};
      end
      SZ_H: begin
        stBe    = 4'b0011 << {stAddrLo[1], 1'b0};
        stWData = {2{stData[15:0]}};
      end
      default: begin
        stBe    = '1;
        stWData = stData;
      end
    endcase
  end

  assign byteShift  = ldData >> {ldAddrLo, 3'b000};
  assign halfShift  = ldData >> {ldAddrLo[1], 4'b0000};
  assign ldUnsigned = ldFunct3[2];

  always_comb begin
    ldResult = ldData;
    case (sizeOf(ldFunct3))
      SZ_B:    ldResult = ldUnsigned ? {{(XLEN-8){1'b0}}, byteShift[7:0]}
                                     : {{(XLEN-8){byteShift[7]}}, byteShift[7:0]};
      SZ_H:    ldResult = ldUnsigned ? {{(XLEN-16){1'b0}}, halfShift[15:0]}
                                     : {{(XLEN-16){halfShift[15]}}, halfShift[15:0]};
      default: ldResult = ldData;
    endcase
  end

endmodule

// File: rtl/pipe_datapath_memory.sv
// M-stage load/store unit: request/response FSM, access latches and W-stage read-data register.
// Define RISCV_LSU_MISALIGN_TRAP_EN to suppress misaligned H/W accesses and pulse o_lsu_MisalignW.
module pipe_datapath_memory
  import pipe_datapath_memory_pkg::*;
#(
  parameter logic [XLEN-1:0] READDATA_INIT = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_ReqM,
  input  logic            i_lsu_WeM,
  input  logic [2:0]      i_lsu_Funct3M,
  input  logic [XLEN-1:0] i_lsu_AddrM,
  input  logic [XLEN-1:0] i_lsu_WriteDataM,
  output logic            o_lsu_StallM,
  output logic [XLEN-1:0] o_lsu_ReadDataW,
  output logic            o_lsu_MisalignW,
  output logic            o_dmem_ReqValid,
  input  logic            i_dmem_ReqReady,
  output logic            o_dmem_We,
  output logic [BE_W-1:0] o_dmem_Be,
  output logic [XLEN-1:0] o_dmem_Addr,
  output logic [XLEN-1:0] o_dmem_WData,
  input  logic            i_dmem_RspValid,
  input  logic [XLEN-1:0] i_dmem_RData
);

  lsuState_e       state;
  lsuState_e       nextState;
  dmemReq_t        reqQ;
  logic [2:0]      ldFunct3;
  logic [1:0]      ldAddrLo;
  logic [XLEN-1:0] readDataQ;
  logic            accept;
  logic            capture;
  logic            misalignHit;
  logic            stall;
  logic            reqValid;
  logic [BE_W-1:0] stBe;
  logic [XLEN-1:0] stWData;
  logic [XLEN-1:0] ldResult;

  pipe_datapath_memory_align uAlign (
    .stFunct3 (i_lsu_Funct3M),
    .stAddrLo (i_lsu_AddrM[1:0]),
    .stData   (i_lsu_WriteDataM),
    .stBe     (stBe),
    .stWData  (stWData),
    .ldFunct3 (ldFunct3),
    .ldAddrLo (ldAddrLo),
    .ldData   (i_dmem_RData),
    .ldResult (ldResult)
  );

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic misalignQ;

  assign misalignHit = isMisaligned(i_lsu_Funct3M, i_lsu_AddrM[1:0]);

  // High exactly in the DONE cycle that follows a suppressed access.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) misalignQ <= 1'b0;
    else       misalignQ <= accept & misalignHit;
  end

  assign o_lsu_MisalignW = misalignQ;
`else
  assign misalignHit     = 1'b0;
  assign o_lsu_MisalignW = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= LSU_S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    reqValid  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      LSU_S_IDLE: begin
        if (i_lsu_ReqM) begin
          stall     = 1'b1;
          accept    = 1'b1;
          nextState = misalignHit ? LSU_S_DONE : LSU_S_REQ;
        end
      end
      LSU_S_REQ: begin
        stall    = 1'b1;
        reqValid = 1'b1;
        if (i_dmem_ReqReady) nextState = reqQ.we ? LSU_S_DONE : LSU_S_RSP;
      end
      LSU_S_RSP: begin
        stall = 1'b1;
        if (i_dmem_RspValid) begin
          capture   = 1'b1;
          nextState = LSU_S_DONE;
        end
      end
      LSU_S_DONE: nextState = LSU_S_IDLE;
      default:    nextState = LSU_S_IDLE;
    endcase
  end

  // Request fields are captured once at acceptance so they stay stable while waiting for ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reqQ      <= '0;
      ldFunct3  <= 3'b000;
      ldAddrLo  <= 2'b00;
      readDataQ <= READDATA_INIT;
    end else begin
      if (accept && !misalignHit) begin
        reqQ.we    <= i_lsu_WeM;
        reqQ.be    <= i_lsu_WeM ? stBe : '1;
        reqQ.addr  <= {i_lsu_AddrM[XLEN-1:2], 2'b00};
        reqQ.wdata <= stWData;
        ldFunct3   <= i_lsu_Funct3M;
        ldAddrLo   <= i_lsu_AddrM[1:0];
      end
      if (capture) readDataQ <= ldResult;
    end
  end

  assign o_lsu_StallM    = stall;
  assign o_lsu_ReadDataW = readDataQ;
  assign o_dmem_ReqValid = reqValid;
  assign o_dmem_We       = reqQ.we;
  assign o_dmem_Be       = reqQ.be;
  assign o_dmem_Addr     = reqQ.addr;
  assign o_dmem_WData    = reqQ.wdata;

endmodule

// File: tb/tb_pipe_datapath_memory.sv
// Directed scoreboard bench for pipe_datapath_memory; honours RISCV_LSU_MISALIGN_TRAP_EN.
module tb_pipe_datapath_memory;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } expReq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqM;
  logic        weM;
  logic [2:0]  funct3M;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        stallM;
  logic [31:0] readDataW;
  logic        misalignW;
  logic        reqValid;
  logic        reqReady;
  logic        dmemWe;
  logic [3:0]  dmemBe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWData;
  logic        rspValid;
  logic [31:0] rData;

  int          checks = 0;
  int          errors = 0;
  expReq_t     reqQ[$];
  logic [31:0] ldQ[$];
  logic [31:0] expRd = 32'h0;

  always #5 clk = ~clk;

  pipe_datapath_memory #(.READDATA_INIT(32'h0)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_lsu_ReqM       (reqM),
    .i_lsu_WeM        (weM),
    .i_lsu_Funct3M    (funct3M),
    .i_lsu_AddrM      (addrM),
    .i_lsu_WriteDataM (wdataM),
    .o_lsu_StallM     (stallM),
    .o_lsu_ReadDataW  (readDataW),
    .o_lsu_MisalignW  (misalignW),
    .o_dmem_ReqValid  (reqValid),
    .i_dmem_ReqReady  (reqReady),
    .o_dmem_We        (dmemWe),
    .o_dmem_Be        (dmemBe),
    .o_dmem_Addr      (dmemAddr),
    .o_dmem_WData     (dmemWData),
    .i_dmem_RspValid  (rspValid),
    .i_dmem_RData     (rData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mBe(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000, 3'b100: mBe = 4'b0001 << a[1:0];
      3'b001, 3'b101: mBe = a[1] ? 4'b1100 : 4'b0011;
      default:        mBe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mWData(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000, 3'b100: mWData = {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001, 3'b101: mWData = {d[15:0], d[15:0]};
      default:        mWData = d;
    endcase
  endfunction

  function automatic logic [31:0] mLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b[4];
    logic [7:0]  lo;
    logic [7:0]  hi;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    lo = a[1] ? b[2] : b[0];
    hi = a[1] ? b[3] : b[1];
    case (f3)
      3'b000:  mLoad = {{24{b[a[1:0]][7]}}, b[a[1:0]]};
      3'b100:  mLoad = {24'h0, b[a[1:0]]};
      3'b001:  mLoad = {{16{hi[7]}}, hi, lo};
      3'b101:  mLoad = {16'h0, hi, lo};
      default: mLoad = w;
    endcase
  endfunction

  // One memory op from acceptance to the IDLE cycle after DONE; entered and left just after a rising edge.
  task automatic doOp(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input int readyDly, input int rspDly, input logic [31:0] word);
    expReq_t e;
    expReq_t got;
    logic [31:0] ld;
    reqQ.push_back({we, (we ? mBe(f3, a) : 4'hF), {a[31:2], 2'b00}, mWData(f3, d)});
    if (!we) ldQ.push_back(mLoad(f3, a, word));
    reqM = 1'b1; weM = we; funct3M = f3; addrM = a; wdataM = d;
    #1;
    chk("stall_idle_req", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    e = reqQ.pop_front();
    for (int i = 0; i <= readyDly; i++) begin
      got = {dmemWe, dmemBe, dmemAddr, dmemWData};
      chk("req_valid", 32'(reqValid), 32'd1);
      chk("stall_req", 32'(stallM), 32'd1);
      chk("req_addr", got.addr, e.addr);
      chk("req_be", 32'(got.be), 32'(e.be));
      chk("req_we", 32'(got.we), 32'(e.we));
      if (we) chk("req_wdata", got.wdata, e.wdata);
      if (i == readyDly) reqReady = 1'b1;
      @(posedge clk); #1;
    end
    reqReady = 1'b0;
    if (!we) begin
      for (int i = 0; i <= rspDly; i++) begin
        chk("stall_rsp", 32'(stallM), 32'd1);
        chk("req_dropped", 32'(reqValid), 32'd0);
        if (i == rspDly) begin
          rspValid = 1'b1;
          rData    = word;
        end
        @(posedge clk); #1;
      end
      rspValid = 1'b0;
      rData    = 32'hA5A5_A5A5;
      ld       = ldQ.pop_front();
      expRd    = ld;
    end
    chk("stall_done", 32'(stallM), 32'd0);
    chk("misalign_done", 32'(misalignW), 32'd0);
    chk("read_data", readDataW, expRd);
    reqM = 1'b0;
    @(posedge clk); #1;
    chk("idle_stall", 32'(stallM), 32'd0);
    chk("idle_valid", 32'(reqValid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; reqM = 1'b0; weM = 1'b0; funct3M = 3'b000; addrM = 32'h0; wdataM = 32'h0;
    reqReady = 1'b0; rspValid = 1'b0; rData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_valid", 32'(reqValid), 32'd0);
    chk("rst_rd", readDataW, 32'h0);
    chk("rst_addr", dmemAddr, 32'h0);
    chk("rst_be", 32'(dmemBe), 32'd0);
    chk("rst_misalign", 32'(misalignW), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store, immediate ready
    doOp(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);

    // Loads from a word 0x80F07F01
    doOp(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80F0_7F01);
    chk("lb_spec", readDataW, 32'hFFFF_FF80);
    doOp(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80F0_7F01);
    chk("lbu_spec", readDataW, 32'h0000_0080);
    doOp(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80F0_7F01);
    chk("lh_spec", readDataW, 32'hFFFF_80F0);
    doOp(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80F0_7F01);
    doOp(1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h80F0_7F01);
    doOp(1'b0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h80F0_7F01);
    doOp(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h80F0_7F01);

    // Narrow stores leave ReadDataW alone
    doOp(1'b1, 3'b000, 32'h102, 32'h0000_00AB, 0, 0, 32'h0);
    doOp(1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 32'h0);
    doOp(1'b1, 3'b000, 32'h203, 32'h1122_33C4, 1, 0, 32'h0);
    doOp(1'b1, 3'b001, 32'h200, 32'h5566_7788, 0, 0, 32'h0);
    doOp(1'b1, 3'b111, 32'h204, 32'hCAFE_F00D, 0, 0, 32'h0);

    // Slow ready and slow response
    doOp(1'b0, 3'b010, 32'h104, 32'h0, 3, 2, 32'h1357_9BDF);
    doOp(1'b0, 3'b011, 32'h108, 32'h0, 0, 1, 32'h8642_0ECA);
    doOp(1'b0, 3'b110, 32'h10C, 32'h0, 2, 0, 32'hF000_000F);

    // Reset while waiting for the load response
    reqM = 1'b1; weM = 1'b0; funct3M = 3'b010; addrM = 32'h300;
    @(posedge clk); #1;
    reqReady = 1'b1;
    @(posedge clk); #1;
    reqReady = 1'b0;
    reqM = 1'b0;
    chk("rsp_wait_stall", 32'(stallM), 32'd1);
    rst = 1'b1;
    #2;
    chk("midrst_stall", 32'(stallM), 32'd0);
    chk("midrst_rd", readDataW, 32'h0);
    chk("midrst_valid", 32'(reqValid), 32'd0);
    rst = 1'b0;
    expRd = 32'h0;
    @(posedge clk); #1;
    rspValid = 1'b1; rData = 32'h0000_0055;
    @(posedge clk); #1;
    rspValid = 1'b0;
    chk("late_rsp_rd", readDataW, 32'h0);
    chk("late_rsp_stall", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    chk("late_rsp_idle", 32'(reqValid), 32'd0);

    // Misaligned word load
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    reqM = 1'b1; weM = 1'b0; funct3M = 3'b010; addrM = 32'h101;
    #1;
    chk("mis_stall", 32'(stallM), 32'd1);
    @(posedge clk); #1;
    chk("mis_pulse", 32'(misalignW), 32'd1);
    chk("mis_novalid", 32'(reqValid), 32'd0);
    chk("mis_done_stall", 32'(stallM), 32'd0);
    chk("mis_rd", readDataW, expRd);
    reqM = 1'b0;
    @(posedge clk); #1;
    chk("mis_clear", 32'(misalignW), 32'd0);
    chk("mis_idle_valid", 32'(reqValid), 32'd0);
    doOp(1'b1, 3'b001, 32'h106, 32'h0000_BEEF, 0, 0, 32'h0);
`else
    doOp(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h2468_ACE0);
    chk("mis_ignored_rd", readDataW, 32'h2468_ACE0);
    doOp(1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h8001_7FFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
